// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its prefetch buffer.
package fetch_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of {pc, inst} with a registered head entry.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_inst,
    output logic [31:0] head_pc,
    output logic [31:0] head_inst,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    fetch_entry_t     head_q;
    fetch_entry_t     head_n;
    fetch_entry_t     push_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_n;
    logic [PTR_W-1:0] rd_n;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   cnt_n;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign push_entry = '{pc: push_pc, inst: push_inst};

    always_comb begin
        wr_n   = wr_ptr;
        rd_n   = rd_ptr;
        cnt_n  = count;
        head_n = mem[rd_ptr];
        if (flush) begin
            wr_n   = '0;
            rd_n   = '0;
            cnt_n  = '0;
            head_n = '{pc: 32'h0, inst: NOP};
        end else begin
            if (do_push) wr_n = wr_ptr + 1'b1;
            if (do_pop)  rd_n = rd_ptr + 1'b1;
            if (do_push && !do_pop)      cnt_n = count + 1'b1;
            else if (!do_push && do_pop) cnt_n = count - 1'b1;
            // The only slot written this cycle is wr_ptr, so the new head comes from there or from storage.
            if (do_push && (wr_ptr == rd_n)) head_n = push_entry;
            else                             head_n = mem[rd_n];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (do_push && !flush) mem[wr_ptr] <= push_entry;
            wr_ptr <= wr_n;
            rd_ptr <= rd_n;
            count  <= cnt_n;
            head_q <= head_n;
        end
    end

    assign head_pc   = head_q.pc;
    assign head_inst = head_q.inst;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: loads instruction memory, then streams {pc, inst} to decode through a prefetch buffer.
//   state | meaning
//   LOAD  | loader owns imem writes; no fetch; buffer empty
//   RUN   | sequential fetch into the buffer; redirect flushes; halt returns to LOAD
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 12,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        ld_done,
    input  logic        halt_req,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        running
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_ctrl: DEPTH must be a power of two >= 2");
    end
    if (ADDR_W < 1 || ADDR_W > 30) begin : g_bad_addr_w
        $error("fetch_ctrl: ADDR_W must be within 1..30");
    end

    fetch_state_t state;
    fetch_state_t state_n;
    logic [31:0]  fetch_pc;
    logic [31:0]  pc_n;
    logic         push;
    logic         pop;
    logic         flush;
    logic         full;
    logic         empty;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_pc   (fetch_pc),
        .push_inst (imem_inst),
        .head_pc   (if_pc),
        .head_inst (if_inst),
        .full      (full),
        .empty     (empty)
    );

    assign if_valid   = (state == RUN) && !empty;
    assign running    = (state == RUN);
    assign imem_wdata = ld_data;

    always_comb begin
        state_n   = state;
        pc_n      = fetch_pc;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        ld_ready  = 1'b0;
        imem_we   = 1'b0;
        imem_addr = word_align(fetch_pc);
        case (state)
            LOAD: begin
                // rst_n gating keeps the write strobe dead for the whole reset window.
                ld_ready  = rst_n;
                imem_we   = rst_n && ld_valid;
                imem_addr = word_align(ld_addr);
                if (ld_done) begin
                    state_n = RUN;
                    pc_n    = word_align(RESET_PC);
                    flush   = 1'b1;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_n = LOAD;
                    flush   = 1'b1;
                end else if (redir_valid) begin
                    flush = 1'b1;
                    pc_n  = word_align(redir_pc);
                end else begin
                    pop = if_valid && if_ready;
                    if (!full || pop) begin
                        push = 1'b1;
                        pc_n = fetch_pc + 32'd4;
                    end
                end
            end
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            fetch_pc <= word_align(RESET_PC);
        end else begin
            state    <= state_n;
            fetch_pc <= pc_n;
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after a load completes.
REQ-002 SHALL have parameter ADDR_W, default 12, the word-address width of the instruction memory (4096 words).
REQ-003 SHALL have parameter DEPTH, default 2, the number of prefetch buffer entries (power of two, >=2).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 imem_addr  out  32  byte address to the instruction memory; bits [1:0] always 0.
REQ-007 imem_inst  in  32  instruction word read combinationally at imem_addr.
REQ-008 imem_we  out  1  instruction-memory write strobe.
REQ-009 imem_wdata  out  32  instruction-memory write data.
REQ-010 ld_valid / ld_ready  in / out  1 / 1  loader write handshake.
REQ-011 ld_addr / ld_data  in  32 / 32  loader byte address and word.
REQ-012 ld_done  in  1  single-cycle pulse; loading is finished.
REQ-013 halt_req  in  1  single-cycle pulse; stop fetch and return to LOAD.
REQ-014 redir_valid / redir_pc  in  1 / 32  branch/jump redirect.
REQ-015 if_valid / if_ready  out / in  1 / 1  fetch-to-decode handshake.
REQ-016 if_pc / if_inst  out  32 / 32  PC and instruction of the buffer head.
REQ-017 running  out  1  high in state RUN.

Function
REQ-018 SHALL implement states LOAD and RUN; LOAD->RUN on ld_done; RUN->LOAD on halt_req; no other transitions.
REQ-019 In LOAD: ld_ready=1; imem_we=ld_valid; imem_addr={ld_addr[31:2],2'b00}; imem_wdata=ld_data; no fetch; if_valid=0.
REQ-020 ld_valid with ld_done in the same cycle: the write SHALL complete, then the state moves to RUN.
REQ-021 On LOAD->RUN: fetch_pc SHALL be set to RESET_PC and the buffer SHALL be empty.
REQ-022 In RUN: ld_ready=0; imem_we=0; ld_valid is ignored; imem_addr={fetch_pc[31:2],2'b00}.
REQ-023 In RUN, without a redirect, whenever the buffer is not full or a pop occurs that cycle: the controller SHALL push {fetch_pc, imem_inst} and set fetch_pc += 4 (32-bit wrap).
REQ-024 Latency: a word pushed in cycle N SHALL be visible at if_pc/if_inst with if_valid=1 in cycle N+1; one fetch per cycle is sustained when if_ready=1.
REQ-025 Pop occurs when if_valid && if_ready; buffer order is strictly FIFO; simultaneous push and pop while full SHALL keep the count unchanged.
REQ-026 When the buffer is full and there is no pop: no push; fetch_pc holds.
REQ-027 redir_valid in RUN: flush the buffer; fetch_pc <= {redir_pc[31:2],2'b00}; no push that cycle; if_valid=0 in the next cycle; the first redirected word is visible one cycle later.
REQ-028 A redirect SHALL override a same-cycle pop and push.
REQ-029 halt_req SHALL override a same-cycle redirect; the buffer is flushed, fetch_pc holds, and the state becomes LOAD.
REQ-030 redir_valid and halt_req in LOAD SHALL be ignored.
REQ-031 if_pc/if_inst SHALL hold their value while if_valid && !if_ready.

Reset
REQ-032 While rst_n=0: state=LOAD, buffer empty, fetch_pc=RESET_PC, if_valid=0, imem_we=0, running=0, if_pc=0, if_inst=0.
REQ-033 Reset mid-fetch or mid-write SHALL abort the operation immediately; the next state is LOAD with no further write.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum (LOAD, RUN), the buffer entry struct {pc[31:0], inst[31:0]}, and the NOP constant 32'h0000_0013.
REQ-035 Sub-module fetch_fifo (DEPTH entries, push/pop/flush, full/empty, registered head) SHALL hold the buffer; the controller FSM lives in fetch_ctrl.

Verification
REQ-036 Load test: in LOAD, write ld_addr=0x0,0x4,0x8 with data 0x00100093,0x00200113,0x002081B3, then pulse ld_done -> three imem_we pulses; afterwards if_pc sequence 0x0,0x4,0x8 with the matching if_inst; first if_valid two cycles after ld_done.
REQ-037 Backpressure: if_ready=0 for 5 cycles in RUN -> buffer fills to 2; imem_addr holds at 0x8; if_pc holds at 0x0; on release, 0x0,0x4,0x8 are delivered on consecutive cycles with no gap.
REQ-038 Redirect: redir_valid with redir_pc=0x103 while the buffer is full -> flush; if_valid=0 for one cycle; next if_pc=0x100.
REQ-039 Conflict: halt_req and redir_valid (0x200) in the same cycle -> state LOAD; running=0; if_valid=0; no fetch at 0x200; ld_ready=1 the next cycle.
REQ-040 Wrap: redirect to 0xFFFF_FFFC -> delivered if_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-041 Reset: assert rst_n=0 mid-RUN with the buffer full -> all outputs at reset values within the same cycle; after release the state is LOAD.
